edge_event_unit: RTL and testbench

- Multi-channel successor to the single-line edge detector.
- Each channel has a glitch filter, per-channel edge mode (off/rise/fall/both), and a one-cycle edge pulse.
- Each channel also has a sticky pending flag with acknowledge and an overflow flag; channels are OR-combined into one interrupt.
- Sits between synchronised bus-sniffing lines and the MITM control FSMs or interrupt logic.

---
 rtl/edge_event_unit_pkg.sv | 15 +
 rtl/edge_event_unit_if.sv | 26 ++
 rtl/edge_event_unit_chan.sv | 78 +++++++
 rtl/edge_event_unit.sv | 51 +++++
 tb/tb_edge_event_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_event_unit_pkg.sv
// Shared definitions for the edge event unit: edge mode encoding and
// the sizing helper for the per-channel glitch filter counter.
package edge_event_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Width of a counter that must hold values 0..filter_cycles
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_event_unit_if.sv
// Control/status bundle for the edge event unit. The master side drives the
// monitored lines and configuration; the slave side (the unit) returns the
// filtered levels, pulses, sticky flags and the combined interrupt.
interface edge_event_unit_if #(parameter int CHANNELS = 4);

  logic [CHANNELS-1:0]   sig;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   irq_en;
  logic [CHANNELS-1:0]   ack;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   edge_pulse;
  logic [CHANNELS-1:0]   pending;
  logic [CHANNELS-1:0]   overflow;
  logic                  irq;

  modport master (
    output sig, mode, irq_en, ack,
    input  level, edge_pulse, pending, overflow, irq
  );

  modport slave (
    input  sig, mode, irq_en, ack,
    output level, edge_pulse, pending, overflow, irq
  );

endinterface

// File: rtl/edge_event_unit_chan.sv
// One monitored line: glitch filter with accepted level, edge qualification
// by mode, one-cycle edge pulse, and sticky pending/overflow with W1C ack.
// The next-state pending value is exported so the top can register irq in
// the same cycle that pending rises.
module edge_filter_chan
  import edge_event_pkg::*;
#(
  parameter int FILTER_CYCLES = 1
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       ack,
  output logic       level,
  output logic       edge_pulse,
  output logic       pending,
  output logic       overflow,
  output logic       pending_nxt
);

  localparam int               CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             qualified;
  logic             overflow_nxt;

  // Edge acceptance, mode qualification and sticky flag next-state;
  // a new edge wins over a simultaneous ack and never flags overflow then
  always_comb begin
    accept       = (sig != level) && (cnt == CNT_LAST);
    qualified    = 1'b0;
    pending_nxt  = pending;
    overflow_nxt = overflow;
    if (accept) begin
      qualified = sig ? ((mode & MODE_RISE) != MODE_OFF)
                      : ((mode & MODE_FALL) != MODE_OFF);
    end
    if (qualified) begin
      pending_nxt = 1'b1;
      if (pending && !ack) begin
        overflow_nxt = 1'b1;
      end else if (ack) begin
        overflow_nxt = 1'b0;
      end
    end else if (ack) begin
      pending_nxt  = 1'b0;
      overflow_nxt = 1'b0;
    end
  end

  // Filter counter, accepted level and registered event outputs; reset loads
  // the current line level so leaving reset never looks like an edge
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      level      <= sig;
      cnt        <= '0;
      edge_pulse <= 1'b0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (sig == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sig;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      edge_pulse <= qualified;
      pending    <= pending_nxt;
      overflow   <= overflow_nxt;
    end
  end

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: independent filtered edge detectors per
// line, OR-combined into a single registered interrupt.
module edge_event_unit #(
  parameter int CHANNELS      = 4,
  parameter int FILTER_CYCLES = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  edge_event_unit_if.slave  bus
);

  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] pulse_w;
  logic [CHANNELS-1:0] pending_w;
  logic [CHANNELS-1:0] overflow_w;
  logic [CHANNELS-1:0] pending_nxt;
  logic                irq_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_filter_chan #(
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .sig         (bus.sig[i]),
      .mode        (bus.mode[2*i +: 2]),
      .ack         (bus.ack[i]),
      .level       (level_w[i]),
      .edge_pulse  (pulse_w[i]),
      .pending     (pending_w[i]),
      .overflow    (overflow_w[i]),
      .pending_nxt (pending_nxt[i])
    );
  end

  // Interrupt follows next-state pending so it rises together with pending
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(pending_nxt & bus.irq_en);
    end
  end

  assign bus.level      = level_w;
  assign bus.edge_pulse = pulse_w;
  assign bus.pending    = pending_w;
  assign bus.overflow   = overflow_w;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// Bench for edge_event_unit: two instances (filter length 1 and 3) share the
// same stimulus; a sample-history reference model queues expected outputs
// per cycle, which are popped and compared after the clock edge.
module tb_edge_event_unit;
  import edge_event_pkg::*;

  localparam int CH = 4;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic       irq;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst;

  always #5 sys_clk = ~sys_clk;

  edge_event_unit_if #(.CHANNELS(CH)) bus1 ();
  edge_event_unit_if #(.CHANNELS(CH)) bus3 ();

  edge_event_unit #(.CHANNELS(CH), .FILTER_CYCLES(1)) u_dut1 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus1)
  );

  edge_event_unit #(.CHANNELS(CH), .FILTER_CYCLES(3)) u_dut3 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus3)
  );

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [3:0] m_level [2];
  logic [7:0] m_hist  [2][4];
  int         m_valid [2][4];
  logic [3:0] m_pend  [2];
  logic [3:0] m_ovf   [2];
  int         fcyc    [2] = '{1, 3};

  logic [3:0] cur_sig;
  logic [7:0] cur_mode;
  logic [3:0] cur_en;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic checkDut(input string name, input exp_t got, input exp_t want);
    checkOutput({name, ".level"},    32'(got.level), 32'(want.level));
    checkOutput({name, ".pulse"},    32'(got.pulse), 32'(want.pulse));
    checkOutput({name, ".pending"},  32'(got.pend),  32'(want.pend));
    checkOutput({name, ".overflow"}, 32'(got.ovf),   32'(want.ovf));
    checkOutput({name, ".irq"},      32'(got.irq),   32'(want.irq));
  endtask

  // A level is accepted once the newest FILTER samples all differ from it
  task automatic modelStep(input int d, input logic r, input logic [3:0] s,
                           input logic [7:0] m, input logic [3:0] en,
                           input logic [3:0] a, output exp_t e);
    logic acc;
    logic q;
    e = '0;
    if (r) begin
      m_level[d] = s;
      for (int i = 0; i < CH; i++) m_valid[d][i] = 0;
      m_pend[d] = '0;
      m_ovf[d]  = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        m_hist[d][i] = {m_hist[d][i][6:0], s[i]};
        if (m_valid[d][i] < 8) m_valid[d][i]++;
        acc = 1'b0;
        if (m_valid[d][i] >= fcyc[d]) begin
          acc = 1'b1;
          for (int j = 0; j < fcyc[d]; j++)
            if (m_hist[d][i][j] == m_level[d][i]) acc = 1'b0;
        end
        q = 1'b0;
        if (acc) begin
          m_level[d][i] = s[i];
          m_valid[d][i] = 0;
          q = s[i] ? m[2*i] : m[2*i+1];
        end
        e.pulse[i] = q;
        if (q && m_pend[d][i] && !a[i]) m_ovf[d][i] = 1'b1;
        else if (a[i])                  m_ovf[d][i] = 1'b0;
        if (q)         m_pend[d][i] = 1'b1;
        else if (a[i]) m_pend[d][i] = 1'b0;
      end
      e.irq = |(m_pend[d] & en);
    end
    e.level = m_level[d];
    e.pend  = m_pend[d];
    e.ovf   = m_ovf[d];
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] s, input logic [7:0] m,
                               input logic [3:0] en, input logic [3:0] a);
    exp_t e;
    exp_t got;
    @(negedge sys_clk);
    rst = r;
    bus1.sig = s; bus1.mode = m; bus1.irq_en = en; bus1.ack = a;
    bus3.sig = s; bus3.mode = m; bus3.irq_en = en; bus3.ack = a;
    for (int d = 0; d < 2; d++) begin
      modelStep(d, r, s, m, en, a, e);
      exp_q.push_back(e);
    end
    @(posedge sys_clk);
    #1;
    got = {bus1.level, bus1.edge_pulse, bus1.pending, bus1.overflow, bus1.irq};
    checkDut("dut1", got, exp_q.pop_front());
    got = {bus3.level, bus3.edge_pulse, bus3.pending, bus3.overflow, bus3.irq};
    checkDut("dut3", got, exp_q.pop_front());
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b0000);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < CH; i++) begin
        m_hist[d][i]  = '0;
        m_valid[d][i] = 0;
      end

    cur_sig  = 4'b1010;
    cur_mode = {4{MODE_OFF}};
    cur_en   = 4'b1111;

    applyStimulus(1'b1, cur_sig, cur_mode, cur_en, 4'b0000);
    applyStimulus(1'b1, cur_sig, cur_mode, cur_en, 4'b0000);
    hold(10);
    checkOutput("rst_level1", 32'(bus1.level), 32'h0000000A);
    checkOutput("rst_level3", 32'(bus3.level), 32'h0000000A);
    checkOutput("rst_pulse1", 32'(bus1.edge_pulse), 32'h0);
    checkOutput("rst_pend3",  32'(bus3.pending), 32'h0);
    checkOutput("rst_irq1",   32'(bus1.irq), 32'h0);

    cur_mode = {MODE_BOTH, MODE_BOTH, MODE_BOTH, MODE_RISE};

    // Channel 0 rising then falling in rise-only mode
    cur_sig = 4'b1011;
    hold(1);
    checkOutput("ch0_rise_pulse1", 32'(bus1.edge_pulse[0]), 32'h1);
    checkOutput("ch0_rise_pend1",  32'(bus1.pending[0]), 32'h1);
    checkOutput("ch0_rise_irq1",   32'(bus1.irq), 32'h1);
    hold(1);
    checkOutput("ch0_pulse_once1", 32'(bus1.edge_pulse[0]), 32'h0);
    hold(2);
    cur_sig = 4'b1010;
    hold(4);
    applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b1111);

    // Channel 1 glitch versus a held change on the length-3 filter
    cur_sig = 4'b1000;
    hold(5);
    applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b1111);
    cur_sig = 4'b1010;
    hold(2);
    cur_sig = 4'b1000;
    hold(4);
    checkOutput("ch1_glitch_level3", 32'(bus3.level[1]), 32'h0);
    checkOutput("ch1_glitch_pend3",  32'(bus3.pending[1]), 32'h0);
    cur_sig = 4'b1010;
    hold(2);
    checkOutput("ch1_early_level3", 32'(bus3.level[1]), 32'h0);
    hold(1);
    checkOutput("ch1_pulse3", 32'(bus3.edge_pulse[1]), 32'h1);
    checkOutput("ch1_level3", 32'(bus3.level[1]), 32'h1);
    hold(2);
    applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b1111);

    // Channel 2 overflow then acknowledge
    cur_sig = 4'b1110;
    hold(4);
    cur_sig = 4'b1010;
    hold(4);
    checkOutput("ch2_ovf1", 32'(bus1.overflow[2]), 32'h1);
    checkOutput("ch2_ovf3", 32'(bus3.overflow[2]), 32'h1);
    applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b0100);
    checkOutput("ch2_ack_pend1", 32'(bus1.pending[2]), 32'h0);
    checkOutput("ch2_ack_ovf1",  32'(bus1.overflow[2]), 32'h0);
    checkOutput("ch2_ack_pend3", 32'(bus3.pending[2]), 32'h0);
    checkOutput("ch2_ack_ovf3",  32'(bus3.overflow[2]), 32'h0);

    // Channel 3 edge coinciding with ack while pending is set
    cur_sig = 4'b0010;
    hold(4);
    cur_sig = 4'b1010;
    applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b1000);
    checkOutput("ch3_setwins_pend1", 32'(bus1.pending[3]), 32'h1);
    checkOutput("ch3_setwins_ovf1",  32'(bus1.overflow[3]), 32'h0);
    hold(3);
    cur_sig = 4'b0010;
    hold(2);
    applyStimulus(1'b0, cur_sig, cur_mode, cur_en, 4'b1000);
    checkOutput("ch3_setwins_pend3", 32'(bus3.pending[3]), 32'h1);
    checkOutput("ch3_setwins_ovf3",  32'(bus3.overflow[3]), 32'h0);
    hold(1);

    // Dropping irq_en masks the interrupt but keeps pending
    cur_en = 4'b0000;
    hold(1);
    checkOutput("irq_masked3",  32'(bus3.irq), 32'h0);
    checkOutput("pend_kept3",   32'(bus3.pending[3]), 32'h1);
    cur_en = 4'b1111;
    hold(1);

    // Channel 0 off mode tracks level silently, then fall-only mode
    cur_mode[1:0] = MODE_OFF;
    cur_sig[0] = 1'b1; hold(4);
    cur_sig[0] = 1'b0; hold(4);
    cur_sig[0] = 1'b1; hold(4);
    checkOutput("ch0_off_level1", 32'(bus1.level[0]), 32'h1);
    checkOutput("ch0_off_level3", 32'(bus3.level[0]), 32'h1);
    cur_mode[1:0] = MODE_FALL;
    hold(1);
    cur_sig[0] = 1'b0;
    hold(1);
    checkOutput("ch0_fall_pulse1", 32'(bus1.edge_pulse[0]), 32'h1);
    hold(3);

    // Random traffic with occasional reset, ack and configuration changes
    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic [3:0] a;
      r = ($urandom_range(0, 59) == 0);
      cur_sig = cur_sig ^ 4'($urandom & $urandom);
      a = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 19) == 0) cur_mode = 8'($urandom);
      if ($urandom_range(0, 19) == 0) cur_en   = 4'($urandom);
      applyStimulus(r, cur_sig, cur_mode, cur_en, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
